// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's memory stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed, parameterised response latency.
// One request may be outstanding; the response is a single-cycle pulse
// LATENCY cycles after acceptance. Out-of-range addresses return an error
// and never touch the RAM.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    dmem_responder_if.slave bus
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic       LAT_ONE  = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;

    // request fields captured at acceptance
    logic                    lat_write;
    logic                    lat_err;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [31:0]             lat_wdata;
    logic [3:0]              lat_wstrb;

    // fields of the request being committed (live bus when LATENCY == 1)
    logic                    cur_write;
    logic                    cur_err;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [31:0]             cur_wdata;
    logic [3:0]              cur_wstrb;

    logic                    accept;
    logic                    commit;
    logic                    in_err;

    logic                    rsp_valid;
    logic                    rsp_err;
    logic [31:0]             rsp_rdata;

    logic [31:0]             mem [DEPTH];

    assign bus.req_ready  = (state == IDLE) & reset;
    assign bus.busy       = (state != IDLE);
    assign bus.resp_valid = rsp_valid;
    assign bus.resp_err   = rsp_err;
    assign bus.resp_rdata = rsp_rdata;

    assign accept = bus.req_valid & bus.req_ready;
    assign in_err = (bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0;

    // Select the request being committed and detect the edge that enters RESP.
    always_comb begin
        if (state == IDLE) begin
            cur_write = bus.req_write;
            cur_err   = in_err;
            cur_addr  = bus.req_addr[ADDR_WIDTH+1:2];
            cur_wdata = bus.req_wdata;
            cur_wstrb = bus.req_wstrb;
        end else begin
            cur_write = lat_write;
            cur_err   = lat_err;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
            cur_wstrb = lat_wstrb;
        end
        commit = reset & (((state == IDLE) & accept & LAT_ONE) |
                          ((state == WAIT) & (cnt == 4'd0)));
    end

    // Capture request fields on acceptance; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= bus.req_write;
            lat_err   <= in_err;
            lat_addr  <= bus.req_addr[ADDR_WIDTH+1:2];
            lat_wdata <= bus.req_wdata;
            lat_wstrb <= bus.req_wstrb;
        end
    end

    // Byte-strobed RAM write on the commit edge of an in-range store.
    always_ff @(posedge clk) begin
        if (commit & cur_write & ~cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wstrb[i]) begin
                    mem[cur_addr][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (LAT_ONE) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= cur_err;
                rsp_rdata <= (cur_write | cur_err) ? 32'd0 : mem[cur_addr];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1 and 15) driven by
// directed transactions, with a cycle-level reference model and literal
// expectations for the key scenarios.
module tb_dmem_responder;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if b0 ();
    dmem_responder_if b1 ();
    dmem_responder_if b2 ();

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(2))  dut0 (.clk(clk), .reset(rst), .bus(b0));
    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(1))  dut1 (.clk(clk), .reset(rst), .bus(b1));
    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(15)) dut2 (.clk(clk), .reset(rst), .bus(b2));

    logic [2:0]  v;
    logic [2:0]  w;
    logic [31:0] a [3];
    logic [31:0] d [3];
    logic [3:0]  s [3];

    assign b0.req_valid = v[0]; assign b0.req_write = w[0]; assign b0.req_addr = a[0];
    assign b0.req_wdata = d[0]; assign b0.req_wstrb = s[0];
    assign b1.req_valid = v[1]; assign b1.req_write = w[1]; assign b1.req_addr = a[1];
    assign b1.req_wdata = d[1]; assign b1.req_wstrb = s[1];
    assign b2.req_valid = v[2]; assign b2.req_write = w[2]; assign b2.req_addr = a[2];
    assign b2.req_wdata = d[2]; assign b2.req_wstrb = s[2];

    logic [2:0]  rdy;
    logic [2:0]  rv;
    logic [2:0]  re;
    logic [2:0]  bz;
    logic [31:0] rd [3];

    assign rdy = {b2.req_ready, b1.req_ready, b0.req_ready};
    assign rv  = {b2.resp_valid, b1.resp_valid, b0.resp_valid};
    assign re  = {b2.resp_err, b1.resp_err, b0.resp_err};
    assign bz  = {b2.busy, b1.busy, b0.busy};
    assign rd[0] = b0.resp_rdata;
    assign rd[1] = b1.resp_rdata;
    assign rd[2] = b2.resp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    task automatic timeout(input string nm, input int k);
        n_checks++;
        n_errors++;
        $display("FAIL %s[%0d] at %0t: timed out waiting for DUT", nm, k, $time);
    endtask

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // A request accepted in cycle A answers in cycle A+lat, occupies the
    // responder from A+1 to A+lat, and is dropped by any reset edge before.
    bit          pend [3];
    int          acc  [3];
    logic        pw   [3];
    logic [31:0] pa   [3];
    logic [31:0] pd   [3];
    logic [3:0]  ps   [3];
    bit          e_rv [3];
    bit          e_re [3];
    logic [31:0] e_rd [3];
    logic [31:0] mmem [3][1 << AW];
    logic [31:0] mword;
    int          cyc = 0;
    bit          chk_on = 0;

    initial begin
        for (int k = 0; k < 3; k++) begin
            pend[k] = 0; acc[k] = 0; e_rv[k] = 0; e_re[k] = 0; e_rd[k] = 0;
            pw[k] = 0; pa[k] = 0; pd[k] = 0; ps[k] = 0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst) begin
                    pend[k] = 0;
                end else if (!pend[k] && v[k]) begin
                    pend[k] = 1; acc[k] = cyc;
                    pw[k] = w[k]; pa[k] = a[k]; pd[k] = d[k]; ps[k] = s[k];
                end
            end
            if (!rst) chk_on = 1;
            cyc++;
            for (int k = 0; k < 3; k++) begin
                if (pend[k] && cyc > acc[k] + lat_of(k)) pend[k] = 0;
                e_rv[k] = 0; e_re[k] = 0; e_rd[k] = 32'd0;
                if (pend[k] && cyc == acc[k] + lat_of(k)) begin
                    e_rv[k] = 1;
                    if ((pa[k] >> (AW + 2)) != 32'd0) begin
                        e_re[k] = 1;
                    end else if (pw[k]) begin
                        mword = mmem[k][pa[k][AW+1:2]];
                        for (int i = 0; i < 4; i++)
                            if (ps[k][i]) mword[8*i +: 8] = pd[k][8*i +: 8];
                        mmem[k][pa[k][AW+1:2]] = mword;
                    end else begin
                        e_rd[k] = mmem[k][pa[k][AW+1:2]];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int k = 0; k < 3; k++) begin
                    check("req_ready",  k, 32'(rdy[k]), 32'(rst & !pend[k]));
                    check("busy",       k, 32'(bz[k]),  32'(pend[k]));
                    check("resp_valid", k, 32'(rv[k]),  32'(e_rv[k]));
                    check("resp_err",   k, 32'(re[k]),  32'(e_re[k]));
                    check("resp_rdata", k, rd[k],       e_rd[k]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic txn(input int k, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rdo, output logic reo,
                       output int lato, output int waito);
        a[k] = addr; d[k] = wd; s[k] = st; w[k] = wr; v[k] = 1'b1;
        lato = -1; rdo = 32'd0; reo = 1'b0;
        for (waito = 0; waito < 50; waito++) begin
            @(negedge clk);
            if (rdy[k]) break;
            @(posedge clk); #1;
        end
        if (waito >= 50) begin
            timeout("accept", k);
            v[k] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        v[k] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (rv[k]) begin
                lato = n; rdo = rd[k]; reo = re[k];
                break;
            end
        end
        if (lato < 0) timeout("response", k);
        @(posedge clk); #1;
    endtask

    task automatic b2b(input int k, input int run, input int exp_space, input int exp_lat,
                       input logic [31:0] exp0, input logic [31:0] exp1);
        int nacc, nrsp;
        int accs [2];
        int rsps [2];
        logic [31:0] rds [2];
        bit got;
        nacc = 0; nrsp = 0;
        accs[0] = 0; accs[1] = 0; rsps[0] = 0; rsps[1] = 0; rds[0] = 0; rds[1] = 0;
        a[k] = 32'h4; w[k] = 1'b0; s[k] = 4'hF; v[k] = 1'b1;
        for (int n = 0; n < run; n++) begin
            @(negedge clk);
            got = 0;
            if (rdy[k]) begin
                if (nacc < 2) accs[nacc] = n;
                nacc++;
                got = 1;
            end
            if (rv[k]) begin
                if (nrsp < 2) begin rsps[nrsp] = n; rds[nrsp] = rd[k]; end
                nrsp++;
            end
            @(posedge clk); #1;
            if (got) a[k] = (a[k] == 32'h4) ? 32'h8 : 32'h4;
        end
        v[k] = 1'b0;
        if (nacc < 2 || nrsp < 2) begin
            timeout("b2b", k);
        end else begin
            check("b2b_spacing", k, 32'(accs[1] - accs[0]), 32'(exp_space));
            check("b2b_lat0",    k, 32'(rsps[0] - accs[0]), 32'(exp_lat));
            check("b2b_lat1",    k, 32'(rsps[1] - accs[1]), 32'(exp_lat));
            check("b2b_rdata0",  k, rds[0], exp0);
            check("b2b_rdata1",  k, rds[1], exp1);
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    logic [31:0] r_d;
    logic        r_e;
    int          r_l;
    int          r_w;
    int          nresp;

    initial begin
        v = 3'b000; w = 3'b000;
        for (int k = 0; k < 3; k++) begin a[k] = 0; d[k] = 0; s[k] = 0; end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // store then load, LATENCY 2
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r_d, r_e, r_l, r_w);
        check("t1_wr_rdata", 0, r_d, 32'h0);
        check("t1_wr_err",   0, 32'(r_e), 32'h0);
        check("t1_wr_lat",   0, 32'(r_l), 32'd2);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, r_d, r_e, r_l, r_w);
        check("t1_rd_wait",  0, 32'(r_w), 32'd0);
        check("t1_rd_data",  0, r_d, 32'hDEADBEEF);
        check("t1_rd_lat",   0, 32'(r_l), 32'd2);

        // partial strobes
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, r_d, r_e, r_l, r_w);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, r_d, r_e, r_l, r_w);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, r_d, r_e, r_l, r_w);
        check("t2_partial", 0, r_d, 32'h11BB33DD);

        // empty strobe leaves memory unchanged
        txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, r_d, r_e, r_l, r_w);
        check("t2_nostrb_rdata", 0, r_d, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, r_d, r_e, r_l, r_w);
        check("t2_nostrb_keep", 0, r_d, 32'hDEADBEEF);

        // out of range store and load
        txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, r_d, r_e, r_l, r_w);
        txn(0, 1'b1, 32'h00001000, 32'h12345678, 4'hF, r_d, r_e, r_l, r_w);
        check("t4_err",   0, 32'(r_e), 32'h1);
        check("t4_rdata", 0, r_d, 32'h0);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, r_d, r_e, r_l, r_w);
        check("t4_alias_kept", 0, r_d, 32'hCAFEF00D);
        check("t4_alias_err",  0, 32'(r_e), 32'h0);
        txn(0, 1'b0, 32'h80000010, 32'h0, 4'h0, r_d, r_e, r_l, r_w);
        check("t4_rd_err",   0, 32'(r_e), 32'h1);
        check("t4_rd_rdata", 0, r_d, 32'h0);

        // reset during WAIT of a store
        txn(0, 1'b1, 32'h30, 32'h0, 4'hF, r_d, r_e, r_l, r_w);
        a[0] = 32'h30; d[0] = 32'h12345678; s[0] = 4'hF; w[0] = 1'b1; v[0] = 1'b1;
        r_w = 0;
        while (r_w < 50) begin
            @(negedge clk);
            if (rdy[0]) break;
            @(posedge clk); #1;
            r_w++;
        end
        if (r_w >= 50) timeout("t5_accept", 0);
        @(posedge clk); #1;
        v[0] = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        nresp = 0;
        @(negedge clk);
        check("t5_ready_after", 0, 32'(rdy[0]), 32'h1);
        nresp += int'(rv[0]);
        repeat (3) begin
            @(negedge clk);
            nresp += int'(rv[0]);
        end
        check("t5_no_resp", 0, 32'(nresp), 32'd0);
        @(posedge clk); #1;
        txn(0, 1'b0, 32'h30, 32'h0, 4'h0, r_d, r_e, r_l, r_w);
        check("t5_not_written", 0, r_d, 32'h0);

        // request held during reset is not accepted
        rst = 1'b0;
        a[0] = 32'h10; w[0] = 1'b0; v[0] = 1'b1;
        @(negedge clk);
        check("t6_ready_low", 0, 32'(rdy[0]), 32'h0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, r_d, r_e, r_l, r_w);
        check("t6_first_edge", 0, 32'(r_w), 32'd0);
        check("t6_rdata",      0, r_d, 32'hDEADBEEF);

        // back-to-back loads, LATENCY 1 and 15
        txn(1, 1'b1, 32'h4, 32'h11110001, 4'hF, r_d, r_e, r_l, r_w);
        check("t3_l1_wr_lat", 1, 32'(r_l), 32'd1);
        txn(1, 1'b1, 32'h8, 32'h22220002, 4'hF, r_d, r_e, r_l, r_w);
        txn(2, 1'b1, 32'h4, 32'h33330003, 4'hF, r_d, r_e, r_l, r_w);
        check("t3_l15_wr_lat", 2, 32'(r_l), 32'd15);
        txn(2, 1'b1, 32'h8, 32'h44440004, 4'hF, r_d, r_e, r_l, r_w);
        b2b(1, 5,  2,  1,  32'h11110001, 32'h22220002);
        b2b(2, 33, 16, 15, 32'h33330003, 32'h44440004);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog at %0t: simulation did not finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
